// File: rtl/karat_mult_arbiter.sv
// karat_mult_arbiter: round-robin arbiter sharing one Karatsuba multiplier among NREQ requesters.
// Optional WAIT watchdog with multiplier abort is built when KARAT_ARB_TIMEOUT_EN is defined.
module karat_mult_arbiter #(
    parameter int width   = 128,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*width-1:0]  req_a,
    input  logic [NREQ*width-1:0]  req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*width-1:0]     rsp_ab,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [width-1:0]       mul_a,
    output logic [width-1:0]       mul_b,
    output logic                   mul_enable,
    output logic                   mul_reset,
    input  logic [2*width-1:0]     mul_ab,
    input  logic                   mul_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, next;
    logic [IDW-1:0] rr_ptr, gnt, gnt_id;
    logic any_req, abort;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                any_req = 1'b1;
                gnt = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign req_ready  = (state == IDLE && any_req && !reset) ? NREQ'(1) << gnt : '0;
    assign mul_enable = state == ISSUE;
    assign busy       = state != IDLE;

`ifdef KARAT_ARB_TIMEOUT_EN
    logic [15:0] wd;
    logic err_q;
    // A done arriving on the limit cycle suppresses the abort.
    assign abort     = state == WAIT && !mul_done && wd == 16'(TIMEOUT - 1);
    assign rsp_err   = err_q;
    assign mul_reset = reset | abort;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) wd <= '0;
            else if (state == WAIT) wd <= wd + 16'd1;
            if (state == WAIT && (mul_done || abort)) err_q <= abort;
        end
    end
`else
    assign abort     = 1'b0;
    assign rsp_err   = 1'b0;
    assign mul_reset = reset;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = any_req ? ISSUE : IDLE;
            ISSUE:   next = WAIT;
            WAIT:    next = (mul_done || abort) ? RESP : WAIT;
            default: next = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            gnt_id <= '0;
            mul_a <= '0;
            mul_b <= '0;
            rsp_valid <= 1'b0;
            rsp_ab <= '0;
            rsp_id <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                mul_a <= req_a[int'(gnt)*width +: width];
                mul_b <= req_b[int'(gnt)*width +: width];
                gnt_id <= gnt;
            end
            if (state == WAIT && (mul_done || abort)) begin
                rsp_ab <= abort ? '0 : mul_ab;
                rsp_id <= gnt_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
            end
        end
    end
endmodule

// File: doc/karat_mult_arbiter.md
Name: karat_mult_arbiter

Overview:
- Shares one signed Karatsuba multiplier instance among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Per-requester valid/ready request channel; single shared response channel tagged with the requester ID.
- Sits between the MSM point-arithmetic units and the multiplier. It drives the multiplier's enable and reset and consumes its done flag.

Parameters:
- width, 128, operand width in bits; the product is 2*width.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, response ID width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*width  packed signed operand a; requester i occupies bits [i*width +: width].
- req_b  in  NREQ*width  packed signed operand b, same packing as req_a.
- req_ready  out  NREQ  one-hot accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_ab  out  2*width  signed product.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_err  out  1  timeout flag; constant 0 when the optional feature is compiled out.
- busy  out  1  high in every state except IDLE.
- mul_a  out  width  multiplier operand a.
- mul_b  out  width  multiplier operand b.
- mul_enable  out  1  multiplier start pulse.
- mul_reset  out  1  multiplier reset.
- mul_ab  in  2*width  multiplier product.
- mul_done  in  1  multiplier completion flag.

Behaviour:
- Reset values (asynchronous reset asserted):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_ab=0, rsp_id=0, rsp_err=0, busy=0.
  - mul_a=0, mul_b=0, mul_enable=0.
  - mul_reset = reset OR the internal abort pulse.
- Reset asserted mid-operation discards the in-flight operation. The held response is lost and no partial response is ever emitted.
- FSM, state IDLE:
  - grant = first index i, searching from rr_ptr upward with wrap modulo NREQ, such that req_valid[i]=1.
  - req_ready is combinational: req_ready[grant]=1 only in IDLE and only when some req_valid is high. All other bits are 0.
  - On a grant: latch req_a/req_b slice[grant] into mul_a/mul_b, latch gnt_id=grant, go to ISSUE.
- FSM, state ISSUE:
  - mul_enable=1 for exactly this one cycle.
  - Clear the watchdog counter; go to WAIT.
- FSM, state WAIT:
  - mul_a/mul_b held stable. mul_done is ignored in all other states.
  - On mul_done=1: rsp_ab<=mul_ab, rsp_id<=gnt_id, rsp_err<=0, rsp_valid<=1, go to RESP.
- FSM, state RESP:
  - rsp_valid held high; rsp_ab, rsp_id and rsp_err are stable until accepted.
  - On rsp_ready=1: rsp_valid<=0, rr_ptr<=(gnt_id+1) mod NREQ, go to IDLE.
  - No new request is accepted in the same cycle; the next grant is one cycle later at the earliest.
- Latency:
  - Request accepted at cycle T → mul_enable at T+1.
  - mul_done at cycle D → rsp_valid at D+1.
  - With the multiplier latency fixed at L cycles, rsp_valid rises at T+L+2.
- Fairness: a continuously asserted requester is served at most once per NREQ grants while others are pending.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- rr_ptr wraps from NREQ-1 to 0.
- Response backpressure (rsp_ready low) stalls the block indefinitely; req_ready stays 0 throughout.
- Operand and product values are passed through unchanged, with no width or sign manipulation; sign handling belongs to the multiplier wrapper.

Optional Feature:
- Macro: KARAT_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts every cycle spent in WAIT.
  - When the count reaches TIMEOUT with no mul_done: mul_reset pulses for 1 cycle, rsp_ab<=0, rsp_err<=1, rsp_valid<=1, go to RESP.
  - If mul_done arrives in the same cycle the limit is reached, mul_done wins and rsp_err=0.
- Undefined:
  - No counter is built and rsp_err is tied to 0.
  - WAIT waits forever for mul_done.
  - mul_reset = reset.

Test Plan:
- Single request: req0, a=7, b=-3, multiplier model L=5, rsp_ready=1. Expect rsp_ab=-21 and rsp_id=0 with rsp_valid exactly 7 cycles after acceptance, and mul_enable high for exactly 1 cycle.
- Contention: all 4 requesters valid with a=i+1, b=10. Expect grant order 0,1,2,3 and responses 10,20,30,40 with matching rsp_id. With req2 still valid afterwards, the next grant goes to 2 only after the pointer wraps.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid rises while req1 is valid. Expect rsp_ab/rsp_id stable, req_ready=0 and busy=1 throughout; req1 is accepted 1 cycle after the rsp_ready handshake.
- Reset mid-WAIT: assert reset 2 cycles after mul_enable. Expect all outputs at reset values immediately, no response after reset is released, and rr_ptr=0.
- Width boundary: a=-(2**127), b=-1 with width=128. Expect rsp_ab=2**127, sign-correct, passed through unchanged.
- With KARAT_ARB_TIMEOUT_EN and TIMEOUT=16: the multiplier never raises mul_done. Expect a mul_reset pulse, then rsp_err=1 and rsp_ab=0 after 16 WAIT cycles. With the macro undefined, busy stays 1.
